log_xbar: RTL and testbench



---
 rtl/log_xbar_pkg.sv | 10 +
 rtl/log_xbar_rr_arb.sv | 93 +++++++++
 rtl/log_xbar.sv | 130 +++++++++++++
 tb/tb_log_xbar.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_xbar_pkg.sv
// Shared helpers for the logarithmic crossbar.
// Provides the index-width function used to size ports.
package log_xbar_pkg;

  // Width of an index into n items; never zero.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/log_xbar_rr_arb.sv
// Lock-in round-robin arbiter, one per crossbar target.
// Ports: clk_i/rst_ni (sync, active-low), rr_i external
// pointer, req_i/gnt_o/data_i master side, req_o/gnt_i/
// data_o target side.
module log_xbar_rr_arb
  import log_xbar_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          ExtPrio   = 1'b0,
  localparam int         IW        = idx_width(NumIn)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [IW-1:0]              rr_i,
  input  logic [NumIn-1:0]           req_i,
  output logic [NumIn-1:0]           gnt_o,
  input  logic [NumIn*DataWidth-1:0] data_i,
  output logic                       req_o,
  input  logic                       gnt_i,
  output logic [DataWidth-1:0]       data_o
);

  if (NumIn == 1) begin : g_wire
    logic unused_in;
    assign unused_in = ^{clk_i, rst_ni, rr_i};
    assign req_o  = req_i[0];
    assign gnt_o  = req_i & gnt_i;
    assign data_o = req_i[0] ? data_i : '0;
  end else begin : g_arb
    logic [IW-1:0] rr_q;
    logic [IW-1:0] sel_q;
    logic          lock_q;
    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic [IW-1:0] nxt;
    logic          found;
    int unsigned   idx;

    assign ptr = ExtPrio ? rr_i : rr_q;

    // A stalled selection stays put while its master
    // still asks; otherwise scan circularly from ptr.
    always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      if (lock_q && req_i[sel_q]) begin
        sel   = sel_q;
        found = 1'b1;
      end else begin
        for (int i = 0; i < NumIn; i++) begin
          idx = (32'(ptr) + 32'(i)) % NumIn;
          if (!found && req_i[idx]) begin
            found = 1'b1;
            sel   = IW'(idx);
          end
        end
      end
    end

    assign req_o = |req_i;
    assign nxt   = (sel == IW'(NumIn - 1)) ?
                   '0 : sel + 1'b1;

    always_comb begin
      gnt_o = '0;
      if (gnt_i && found) gnt_o[sel] = 1'b1;
    end

    assign data_o = found ?
      data_i[sel*DataWidth +: DataWidth] : '0;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rr_q   <= '0;
        sel_q  <= '0;
        lock_q <= 1'b0;
      end else if (req_o) begin
        if (gnt_i) begin
          lock_q <= 1'b0;
          rr_q   <= nxt;
        end else begin
          lock_q <= 1'b1;
          sel_q  <= sel;
        end
      end else begin
        lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/log_xbar.sv
// NumIn x NumOut logarithmic crossbar for TCDM targets.
// Ports: clk_i, rst_ni (sync, active-low), rr_i priority,
// master side req_i/add_i/wen_i/wdata_i/gnt_o/vld_o/rdata_o,
// target side req_o/wdata_o/gnt_i/rdata_i.
// Macro LOG_XBAR_BROADCAST_EN sends every request to all
// targets; responses then come from target 0.
module log_xbar
  import log_xbar_pkg::*;
#(
  parameter int unsigned NumIn         = 4,
  parameter int unsigned NumOut        = 4,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter bit          WriteRespOn   = 1'b1,
  parameter bit          ExtPrio       = 1'b0,
  localparam int         IW = idx_width(NumIn),
  localparam int         AW = idx_width(NumOut)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NumOut*IW-1:0]           rr_i,
  input  logic [NumIn-1:0]               req_i,
  input  logic [NumIn*AW-1:0]            add_i,
  input  logic [NumIn-1:0]               wen_i,
  input  logic [NumIn*ReqDataWidth-1:0]  wdata_i,
  output logic [NumIn-1:0]               gnt_o,
  output logic [NumIn-1:0]               vld_o,
  output logic [NumIn*RespDataWidth-1:0] rdata_o,
  input  logic [NumOut-1:0]              gnt_i,
  output logic [NumOut-1:0]              req_o,
  output logic [NumOut*ReqDataWidth-1:0] wdata_o,
  input  logic [NumOut*RespDataWidth-1:0] rdata_i
);

  logic [NumOut-1:0][NumIn-1:0] treq;
  logic [NumOut-1:0][NumIn-1:0] tgnt;
  logic unused_add;

  assign unused_add = ^add_i;

  for (genvar k = 0; k < NumOut; k++) begin : g_arb
    log_xbar_rr_arb #(
      .NumIn     (NumIn),
      .DataWidth (ReqDataWidth),
      .ExtPrio   (ExtPrio)
    ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .rr_i   (rr_i[k*IW +: IW]),
      .req_i  (treq[k]),
      .gnt_o  (tgnt[k]),
      .data_i (wdata_i),
      .req_o  (req_o[k]),
      .gnt_i  (gnt_i[k]),
      .data_o (wdata_o[k*ReqDataWidth +: ReqDataWidth])
    );
  end

  // A master is granted only when every target it asked
  // agrees: one target in unicast, all in broadcast.
  always_comb begin
    for (int j = 0; j < NumIn; j++) begin
`ifdef LOG_XBAR_BROADCAST_EN
      gnt_o[j] = req_i[j];
      for (int k = 0; k < NumOut; k++)
        gnt_o[j] = gnt_o[j] & tgnt[k][j];
`else
      gnt_o[j] = 1'b0;
      for (int k = 0; k < NumOut; k++)
        gnt_o[j] = gnt_o[j] | tgnt[k][j];
      gnt_o[j] = gnt_o[j] & req_i[j];
`endif
    end
  end

  for (genvar j = 0; j < NumIn; j++) begin : g_mst
    logic [AW-1:0] add_in;
    logic          resp_in;
    logic [RespLat-1:0]         v_q;
    logic [RespLat-1:0][AW-1:0] a_q;
    logic [RespDataWidth-1:0]   rd;

`ifdef LOG_XBAR_BROADCAST_EN
    for (genvar k = 0; k < NumOut; k++) begin : g_tgt
      assign treq[k][j] = req_i[j];
    end
    assign add_in = '0;
`else
    if (NumOut == 1) begin : g_one
      assign treq[0][j] = req_i[j];
      assign add_in     = '0;
    end else begin : g_dec
      assign add_in = add_i[j*AW +: AW];
      for (genvar k = 0; k < NumOut; k++) begin : g_tgt
        assign treq[k][j] = req_i[j] &
                            (add_in == AW'(k));
      end
    end
`endif

    assign resp_in = gnt_o[j] &
                     (~wen_i[j] | WriteRespOn);

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        v_q <= '0;
        a_q <= '0;
      end else begin
        v_q[0] <= resp_in;
        a_q[0] <= add_in;
        for (int i = 1; i < RespLat; i++) begin
          v_q[i] <= v_q[i-1];
          a_q[i] <= a_q[i-1];
        end
      end
    end

    always_comb begin
      rd = '0;
      for (int k = 0; k < NumOut; k++)
        if (a_q[RespLat-1] == AW'(k))
          rd = rdata_i[k*RespDataWidth +: RespDataWidth];
    end

    assign vld_o[j] = v_q[RespLat-1];
    assign rdata_o[j*RespDataWidth +: RespDataWidth] = rd;
  end

endmodule

// File: tb/tb_log_xbar.sv
// Self-checking bench for log_xbar: three instances
// sharing inputs, compared against a behavioural model.
module tb_log_xbar;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   req, wen, gnt_in;
  logic [7:0]   add, rr;
  logic [127:0] wdata, rdata;

  logic [3:0]   x_gnt [3];
  logic [3:0]   x_vld [3];
  logic [3:0]   x_req [3];
  logic [127:0] x_wd  [3];
  logic [127:0] x_rd  [3];

  // a: lat1 wr1 int; b: lat3 wr0 ext; c: lat2 wr1 int
  int lat [3] = '{1, 3, 2};
  bit wr  [3] = '{1'b1, 1'b0, 1'b1};
  bit ext [3] = '{1'b0, 1'b1, 1'b0};

  int ptr [3][4];
  int lk  [3][4];
  bit ev  [3][4][4096];
  int ea  [3][4][4096];
  int cyc;
  int nvec, nerr;

  log_xbar #(.RespLat(1), .WriteRespOn(1'b1),
             .ExtPrio(1'b0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr),
    .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .gnt_o(x_gnt[0]),
    .vld_o(x_vld[0]), .rdata_o(x_rd[0]),
    .gnt_i(gnt_in), .req_o(x_req[0]),
    .wdata_o(x_wd[0]), .rdata_i(rdata));

  log_xbar #(.RespLat(3), .WriteRespOn(1'b0),
             .ExtPrio(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr),
    .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .gnt_o(x_gnt[1]),
    .vld_o(x_vld[1]), .rdata_o(x_rd[1]),
    .gnt_i(gnt_in), .req_o(x_req[1]),
    .wdata_o(x_wd[1]), .rdata_i(rdata));

  log_xbar #(.RespLat(2), .WriteRespOn(1'b1),
             .ExtPrio(1'b0)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr),
    .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .gnt_o(x_gnt[2]),
    .vld_o(x_vld[2]), .rdata_o(x_rd[2]),
    .gnt_i(gnt_in), .req_o(x_req[2]),
    .wdata_o(x_wd[2]), .rdata_i(rdata));

  // ---- reference model ----
  function automatic int tgt(int j);
    return int'(add[j*2 +: 2]);
  endfunction

  function automatic int msel(int d, int k);
    int p, m;
    if (lk[d][k] >= 0 && req[lk[d][k]] &&
        tgt(lk[d][k]) == k)
      return lk[d][k];
    p = ext[d] ? int'(rr[k*2 +: 2]) : ptr[d][k];
    for (int i = 0; i < 4; i++) begin
      m = (p + i) % 4;
      if (req[m] && tgt(m) == k) return m;
    end
    return -1;
  endfunction

  function automatic logic [3:0] mgnt(int d);
    logic [3:0] g;
    g = '0;
    for (int j = 0; j < 4; j++)
      if (req[j] && gnt_in[tgt(j)] &&
          msel(d, tgt(j)) == j)
        g[j] = 1'b1;
    return g;
  endfunction

  function automatic logic [3:0] mreq();
    logic [3:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      if (req[j]) r[tgt(j)] = 1'b1;
    return r;
  endfunction

  function automatic logic [127:0] mwd(int d);
    logic [127:0] w;
    int s;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      s = msel(d, k);
      if (s >= 0) w[k*32 +: 32] = wdata[s*32 +: 32];
    end
    return w;
  endfunction

  // Advance model and DUTs by one clock edge.
  task automatic tick();
    logic [3:0] g;
    int s [4];
    for (int d = 0; d < 3; d++) begin
      g = mgnt(d);
      for (int k = 0; k < 4; k++) s[k] = msel(d, k);
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          ptr[d][k] = 0;
          lk[d][k]  = -1;
        end
        for (int j = 0; j < 4; j++)
          for (int l = 1; l <= 3; l++)
            ev[d][j][cyc+l] = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (s[k] < 0) lk[d][k] = -1;
          else if (gnt_in[k]) begin
            ptr[d][k] = (s[k] + 1) % 4;
            lk[d][k]  = -1;
          end else lk[d][k] = s[k];
        end
        for (int j = 0; j < 4; j++)
          if (g[j] && (!wen[j] || wr[d])) begin
            ev[d][j][cyc+lat[d]] = 1'b1;
            ea[d][j][cyc+lat[d]] = tgt(j);
          end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    req = '0;
    wen = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0; req = '0; add = '0; wen = '0;
    wdata = '0; gnt_in = 4'hF; rr = '0;
    rdata = {32'hCAFE_0003, 32'hCAFE_0002,
             32'hCAFE_0001, 32'hCAFE_0000};
    tick(); tick();
    #1;
    for (int d = 0; d < 3; d++) begin
      nvec++;
      if (x_vld[d] !== 4'b0) begin
        nerr++;
        $display("FAIL reset_vld d%0d: got %b want 0000",
                 d, x_vld[d]);
      end
      nvec++;
      if (x_rd[d] !== {4{32'hCAFE_0000}}) begin
        nerr++;
        $display("FAIL reset_rdata d%0d: got %h", d,
                 x_rd[d]);
      end
    end
    req = 4'b0001; add = 8'd1; #1;
    nvec++;
    if (x_req[0] !== 4'b0010) begin
      nerr++;
      $display("FAIL reset_req_comb: got %b want 0010",
               x_req[0]);
    end
    req = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast_load();
    idle(2);
    req = 4'b0001; add = 8'b0000_0010; wen = '0;
    wdata[31:0] = 32'hA5A5_0001; gnt_in = 4'hF;
    #1;
    nvec++;
    if (x_req[0] !== 4'b0100) begin
      nerr++;
      $display("FAIL load_req: got %b want 0100",
               x_req[0]);
    end
    nvec++;
    if (x_wd[0][95:64] !== 32'hA5A5_0001) begin
      nerr++;
      $display("FAIL load_wdata: got %h want a5a50001",
               x_wd[0][95:64]);
    end
    nvec++;
    if (x_gnt[0] !== 4'b0001) begin
      nerr++;
      $display("FAIL load_gnt: got %b want 0001",
               x_gnt[0]);
    end
    tick();
    req = '0;
    #1;
    nvec++;
    if (x_vld[0] !== 4'b0001) begin
      nerr++;
      $display("FAIL load_vld: got %b want 0001",
               x_vld[0]);
    end
    nvec++;
    if (x_rd[0][31:0] !== 32'hCAFE_0002) begin
      nerr++;
      $display("FAIL load_rdata: got %h want cafe0002",
               x_rd[0][31:0]);
    end
    tick();
  endtask

  task automatic test_rotate();
    logic [3:0] exp;
    idle(4);
    req = 4'hF; add = 8'b01_01_01_01; gnt_in = 4'hF;
    for (int c = 0; c < 5; c++) begin
      exp = 4'b0001 << (c % 4);
      #1;
      nvec++;
      if (x_gnt[0] !== exp) begin
        nerr++;
        $display("FAIL rotate c%0d: got %b want %b",
                 c, x_gnt[0], exp);
      end
      tick();
    end
  endtask

  task automatic test_lock_stall();
    idle(4);
    rr = '0; req = 4'b0101; add = 8'b00_11_00_11;
    wdata[31:0]  = 32'h1111_0000;
    wdata[95:64] = 32'h2222_0000;
    gnt_in = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) rr[7:6] = 2'd2;
      #1;
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (x_wd[d][127:96] !== 32'h1111_0000) begin
          nerr++;
          $display("FAIL stall_sel d%0d c%0d: got %h",
                   d, c, x_wd[d][127:96]);
        end
        nvec++;
        if (x_gnt[d] !== 4'b0000) begin
          nerr++;
          $display("FAIL stall_gnt d%0d c%0d: got %b",
                   d, c, x_gnt[d]);
        end
      end
      tick();
    end
    gnt_in = 4'hF;
    #1;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (x_gnt[d] !== 4'b0001) begin
        nerr++;
        $display("FAIL stall_release d%0d: got %b want 0001",
                 d, x_gnt[d]);
      end
    end
    tick();
    req = 4'b0100;
    #1;
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (x_gnt[d] !== 4'b0100) begin
        nerr++;
        $display("FAIL stall_next d%0d: got %b want 0100",
                 d, x_gnt[d]);
      end
    end
    tick();
    rr = '0;
  endtask

  task automatic test_write_resp();
    logic [3:0] ea_;
    idle(4);
    req = 4'b0001; add = '0; wen = 4'b0001;
    gnt_in = 4'hF;
    tick();
    req = '0; wen = '0;
    #1;
    ea_ = x_vld[0];
    nvec++;
    if (ea_ !== 4'b0001 || x_vld[1] !== 4'b0) begin
      nerr++;
      $display("FAIL wr_lat1: got a=%b b=%b want 0001/0000",
               ea_, x_vld[1]);
    end
    tick();
    #1;
    nvec++;
    if (x_vld[2] !== 4'b0001 || x_vld[1] !== 4'b0) begin
      nerr++;
      $display("FAIL wr_lat2: got c=%b b=%b want 0001/0000",
               x_vld[2], x_vld[1]);
    end
    tick();
    #1;
    nvec++;
    if (x_vld[1] !== 4'b0) begin
      nerr++;
      $display("FAIL wr_off: got %b want 0000", x_vld[1]);
    end
    idle(3);
    req = 4'b0001; wen = '0;
    tick();
    req = '0;
    tick();
    #1;
    nvec++;
    if (x_vld[1] !== 4'b0) begin
      nerr++;
      $display("FAIL ld_lat3_early: got %b want 0000",
               x_vld[1]);
    end
    tick();
    #1;
    nvec++;
    if (x_vld[1] !== 4'b0001 ||
        x_rd[1][31:0] !== 32'hCAFE_0000) begin
      nerr++;
      $display("FAIL ld_lat3: got %b %h want 0001 cafe0000",
               x_vld[1], x_rd[1][31:0]);
    end
    tick();
  endtask

  task automatic test_ext_prio();
    idle(4);
    rr = 8'b0000_1000; req = 4'b1001;
    add = 8'b01_00_00_01; gnt_in = 4'hF;
    #1;
    nvec++;
    if (x_gnt[1] !== 4'b1000) begin
      nerr++;
      $display("FAIL ext_prio2: got %b want 1000",
               x_gnt[1]);
    end
    rr = '0;
    #1;
    nvec++;
    if (x_gnt[1] !== 4'b0001) begin
      nerr++;
      $display("FAIL ext_prio0: got %b want 0001",
               x_gnt[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(4);
    req = 4'b0010; add = '0; wen = '0; gnt_in = 4'hF;
    #1;
    nvec++;
    if (x_gnt[2] !== 4'b0010) begin
      nerr++;
      $display("FAIL rmid_gnt: got %b want 0010", x_gnt[2]);
    end
    tick();
    rst_n = 1'b0; req = '0;
    tick();
    rst_n = 1'b1;
    #1;
    nvec++;
    if (x_vld[2] !== 4'b0) begin
      nerr++;
      $display("FAIL rmid_vld: got %b want 0000", x_vld[2]);
    end
    tick();
    #1;
    nvec++;
    if (x_vld[2] !== 4'b0) begin
      nerr++;
      $display("FAIL rmid_vld2: got %b want 0000",
               x_vld[2]);
    end
    req = 4'hF; add = '0;
    #1;
    nvec++;
    if (x_gnt[2] !== 4'b0001) begin
      nerr++;
      $display("FAIL rmid_prio: got %b want 0001",
               x_gnt[2]);
    end
    tick();
  endtask

  task automatic test_random();
    int a;
    idle(2);
    for (int n = 0; n < 1500; n++) begin
      for (int j = 0; j < 4; j++)
        if (!(req[j] && $urandom_range(3) != 0)) begin
          req[j] = 1'($urandom_range(1));
          add[j*2 +: 2] = 2'($urandom);
          wen[j] = 1'($urandom);
          wdata[j*32 +: 32] = $urandom;
        end
      gnt_in = 4'($urandom | $urandom);
      rdata = {$urandom, $urandom, $urandom, $urandom};
      rr = 8'($urandom);
      rst_n = ($urandom_range(99) != 0);
      #1;
      for (int d = 0; d < 3; d++) begin
        nvec++;
        if (x_gnt[d] !== mgnt(d)) begin
          nerr++;
          $display("FAIL rnd_gnt d%0d cyc%0d: got %b want %b",
                   d, cyc, x_gnt[d], mgnt(d));
        end
        nvec++;
        if (x_req[d] !== mreq()) begin
          nerr++;
          $display("FAIL rnd_req d%0d cyc%0d: got %b want %b",
                   d, cyc, x_req[d], mreq());
        end
        nvec++;
        if (x_wd[d] !== mwd(d)) begin
          nerr++;
          $display("FAIL rnd_wdata d%0d cyc%0d: got %h want %h",
                   d, cyc, x_wd[d], mwd(d));
        end
        for (int j = 0; j < 4; j++) begin
          nvec++;
          if (x_vld[d][j] !== ev[d][j][cyc]) begin
            nerr++;
            $display("FAIL rnd_vld d%0d m%0d cyc%0d: got %b want %b",
                     d, j, cyc, x_vld[d][j], ev[d][j][cyc]);
          end
          if (ev[d][j][cyc]) begin
            a = ea[d][j][cyc];
            nvec++;
            if (x_rd[d][j*32 +: 32] !== rdata[a*32 +: 32]) begin
              nerr++;
              $display("FAIL rnd_rdata d%0d m%0d: got %h want %h",
                       d, j, x_rd[d][j*32 +: 32],
                       rdata[a*32 +: 32]);
            end
          end
        end
      end
      tick();
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) begin
        ptr[d][k] = 0;
        lk[d][k]  = -1;
      end
    test_reset();
    test_unicast_load();
    test_rotate();
    test_lock_stall();
    test_write_resp();
    test_ext_prio();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
